fpnew_divsqrt_iter_core: RTL and testbench

Iterative radix-2 mantissa divide / square-root core that executes operations issued by the FPU's div/sqrt control FSM. It accepts a start pulse when ready, retires one quotient/root bit per cycle, and pulses done for exactly one cycle with a registered result and sticky bit. Sign, exponent, special-case, and rounding logic stay in the issuing wrapper. This core implements only the responder side of the start / kill / ready / done protocol.

---
 rtl/fpnew_divsqrt_iter_core.sv | 127 ++++++++++++
 tb/tb_fpnew_divsqrt_iter_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_divsqrt_iter_core.sv
// fpnew_divsqrt_iter_core
//   Iterative radix-2 mantissa divide / square-root core. One quotient or root bit is
//   retired per BUSY cycle, MSB first; done_o pulses for one cycle with the result.
//   Sign, exponent, special cases and rounding are handled by the issuing wrapper.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   div_start_i         start a division (only when ready_o)
//   sqrt_start_i        start a square root (only when ready_o); division wins if both
//   kill_i              abort current operation, return to idle, no done_o
//   mant_a_i, mant_b_i  dividend/radicand and divisor mantissas (hidden bit set)
//   sqrt_odd_exp_i      sqrt only: radicand doubled
//   ready_o, done_o, busy_o  decoded from the state register
//   result_o            MANT_WIDTH+2 bit quotient / root (1 integer bit)
//   sticky_o            final partial remainder non-zero
module fpnew_divsqrt_iter_core #(
    parameter int unsigned MANT_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  div_start_i,
    input  logic                  sqrt_start_i,
    input  logic                  kill_i,
    input  logic [MANT_WIDTH-1:0] mant_a_i,
    input  logic [MANT_WIDTH-1:0] mant_b_i,
    input  logic                  sqrt_odd_exp_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [MANT_WIDTH+1:0] result_o,
    output logic                  sticky_o
);

    localparam int unsigned RW = MANT_WIDTH + 2;
    localparam int unsigned CW = $clog2(RW);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [CW-1:0]     r_cnt;
    logic              r_is_sqrt;
    logic [MANT_WIDTH-1:0] r_b;
    // Partial remainder: division uses the low MANT_WIDTH+1 bits, sqrt all RW+1.
    logic [RW:0]       r_rem;
    // Radicand shift register; two bits are consumed per sqrt iteration.
    logic [2*RW-1:0]   r_rad;
    logic [RW-1:0]     r_q;
    logic              r_sticky;

    logic              w_start;
    logic [MANT_WIDTH:0] w_div_r;
    logic              w_div_ge;
    logic [MANT_WIDTH:0] w_div_sub;
    logic [RW+2:0]     w_sq_shift;
    logic [RW+2:0]     w_sq_trial;
    logic              w_sq_ge;
    logic [RW:0]       w_sq_rem;
    logic              w_bit;
    logic [MANT_WIDTH:0] w_rad_init;

    assign ready_o  = (r_state == StIdle) || (r_state == StDone);
    assign busy_o   = (r_state == StBusy);
    assign done_o   = (r_state == StDone);
    assign result_o = r_q;
    assign sticky_o = r_sticky;

    assign w_start = (div_start_i | sqrt_start_i) & ready_o & ~kill_i;

    // Division step: subtract divisor when it fits, then shift left.
    assign w_div_r   = r_rem[MANT_WIDTH:0];
    assign w_div_ge  = w_div_r >= {1'b0, r_b};
    assign w_div_sub = w_div_ge ? (w_div_r - {1'b0, r_b}) : w_div_r;

    // Restoring sqrt step: bring down two radicand bits, try subtracting 4*root+1.
    assign w_sq_shift = {r_rem, r_rad[2*RW-1 -: 2]};
    assign w_sq_trial = {1'b0, r_q, 2'b01};
    assign w_sq_ge    = w_sq_shift >= w_sq_trial;
    assign w_sq_rem   = w_sq_ge ? (RW+1)'(w_sq_shift - w_sq_trial) : w_sq_shift[RW:0];

    assign w_bit      = r_is_sqrt ? w_sq_ge : w_div_ge;
    assign w_rad_init = sqrt_odd_exp_i ? {mant_a_i, 1'b0} : {1'b0, mant_a_i};

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_start) w_state_d = StBusy;
            StBusy:  if (r_cnt == '0) w_state_d = StDone;
            StDone:  w_state_d = w_start ? StBusy : StIdle;
            default: w_state_d = StIdle;
        endcase
        if (kill_i) w_state_d = StIdle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_is_sqrt <= 1'b0;
            r_b       <= '0;
            r_rem     <= '0;
            r_rad     <= '0;
            r_q       <= '0;
            r_sticky  <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= CW'(RW - 1);
            r_is_sqrt <= ~div_start_i;
            r_b       <= mant_b_i;
            r_rem     <= div_start_i ? {2'b00, 1'b0, mant_a_i} : '0;
            r_rad     <= {w_rad_init, (MANT_WIDTH+3)'(0)};
            r_q       <= '0;
        end else if (r_state == StBusy) begin
            r_cnt    <= r_cnt - CW'(1);
            r_q      <= {r_q[RW-2:0], w_bit};
            r_rad    <= {r_rad[2*RW-3:0], 2'b00};
            r_rem    <= r_is_sqrt ? w_sq_rem : {2'b00, w_div_sub[MANT_WIDTH-1:0], 1'b0};
            r_sticky <= r_is_sqrt ? (w_sq_rem != '0) : (w_div_sub != '0);
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_iter_core.sv
// Testbench for fpnew_divsqrt_iter_core (MANT_WIDTH=24). Expected results come from a
// behavioural model, are queued when an operation is issued and popped at done_o.
module tb_fpnew_divsqrt_iter_core;

    localparam int unsigned MW  = 24;
    localparam int unsigned RW  = MW + 2;
    localparam int          LAT = 27;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_start;
    logic          sqrt_start;
    logic          kill;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          odd;
    logic          ready_o;
    logic          done_o;
    logic          busy_o;
    logic [RW-1:0] result_o;
    logic          sticky_o;

    exp_t sb_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    fpnew_divsqrt_iter_core #(.MANT_WIDTH(MW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .div_start_i    (div_start),
        .sqrt_start_i   (sqrt_start),
        .kill_i         (kill),
        .mant_a_i       (a),
        .mant_b_i       (b),
        .sqrt_odd_exp_i (odd),
        .ready_o        (ready_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .sticky_o       (sticky_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model_div(input logic [MW-1:0] aa, input logic [MW-1:0] bb);
        exp_t        e;
        logic [63:0] n;
        logic [63:0] q;
        n     = 64'(aa) << (MW + 1);
        q     = n / 64'(bb);
        e.res = q[RW-1:0];
        e.st  = (n % 64'(bb)) != 64'd0;
        return e;
    endfunction

    function automatic exp_t model_sqrt(input logic [MW-1:0] aa, input logic o);
        exp_t        e;
        logic [63:0] v;
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] mid;
        v  = (o ? (64'(aa) << 1) : 64'(aa)) << (MW + 3);
        lo = 64'd0;
        hi = 64'd1 << 27;
        while (hi - lo > 64'd1) begin
            mid = (lo + hi) >> 1;
            if (mid * mid <= v) lo = mid;
            else hi = mid;
        end
        e.res = lo[RW-1:0];
        e.st  = (lo * lo) != v;
        return e;
    endfunction

    // Issues one operation at the current negedge and waits for its done_o, checking
    // latency, ready_o low while busy, and the popped expected result. Returns at the
    // negedge of the DONE cycle so a following call issues back-to-back.
    task automatic run_op(input logic d, input logic s, input logic [MW-1:0] aa,
                          input logic [MW-1:0] bb, input logic o, input string name);
        exp_t e;
        int   c;
        bit   seen_ready;
        bit   done_seen;
        sb_q.push_back(d ? model_div(aa, bb) : model_sqrt(aa, o));
        div_start  = d;
        sqrt_start = s;
        a          = aa;
        b          = bb;
        odd        = o;
        seen_ready = 0;
        done_seen  = 0;
        c          = 0;
        while (c < LAT + 8 && !done_seen) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                div_start  = 1'b0;
                sqrt_start = 1'b0;
            end
            if (done_o) done_seen = 1;
            else if (ready_o) seen_ready = 1;
        end
        e = sb_q.pop_front();
        n_run++;
        if (!done_seen || c != LAT) begin
            $display("FAIL %s latency: got %0d (done seen %0d), required %0d", name, c,
                     done_seen, LAT);
            n_fail++;
        end
        n_run++;
        if (seen_ready) begin
            $display("FAIL %s ready_busy: got ready_o=1 while busy, required 0", name);
            n_fail++;
        end
        n_run++;
        if (result_o !== e.res) begin
            $display("FAIL %s result: got %h, required %h", name, result_o, e.res);
            n_fail++;
        end
        n_run++;
        if (sticky_o !== e.st) begin
            $display("FAIL %s sticky: got %b, required %b", name, sticky_o, e.st);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
        a = '0; b = '0; odd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_run++;
        if ({ready_o, done_o, busy_o, result_o, sticky_o} !== {3'b100, {RW{1'b0}}, 1'b0}) begin
            $display("FAIL reset: got rdy=%b done=%b busy=%b res=%h st=%b, required 1 0 0 0 0",
                     ready_o, done_o, busy_o, result_o, sticky_o);
            n_fail++;
        end
    endtask

    task automatic test_div();
        run_op(1'b1, 1'b0, 24'h800000, 24'h800000, 1'b0, "div_1_1");
        @(negedge clk);
        run_op(1'b1, 1'b0, 24'hC00000, 24'h800000, 1'b0, "div_1.5_1");
        @(negedge clk);
        run_op(1'b1, 1'b0, 24'h800000, 24'hC00000, 1'b0, "div_1_1.5");
        @(negedge clk);
        run_op(1'b1, 1'b0, 24'hFFFFFF, 24'h800001, 1'b0, "div_max");
        @(negedge clk);
    endtask

    task automatic test_sqrt();
        run_op(1'b0, 1'b1, 24'h800000, 24'h000000, 1'b0, "sqrt_even");
        @(negedge clk);
        run_op(1'b0, 1'b1, 24'h800000, 24'h123456, 1'b1, "sqrt_odd");
        @(negedge clk);
        run_op(1'b0, 1'b1, 24'hFFFFFF, 24'h000000, 1'b1, "sqrt_max_odd");
        @(negedge clk);
    endtask

    task automatic test_kill();
        int c;
        bit done_seen;
        done_seen = 0;
        div_start = 1'b1; a = 24'hA00000; b = 24'h900000;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) div_start = 1'b0;
            if (done_o) done_seen = 1;
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        n_run++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || done_seen) begin
            $display("FAIL kill_state: got rdy=%b busy=%b done=%b early_done=%b, required 1 0 0 0",
                     ready_o, busy_o, done_o, done_seen);
            n_fail++;
        end
        run_op(1'b1, 1'b0, 24'hE00000, 24'hA00000, 1'b0, "after_kill");
        @(negedge clk);
        // Kill together with a start in idle drops the start.
        div_start = 1'b1; kill = 1'b1;
        @(negedge clk);
        div_start = 1'b0; kill = 1'b0;
        done_seen = 0;
        for (c = 0; c < LAT + 3; c++) begin
            if (busy_o || done_o || !ready_o) done_seen = 1;
            @(negedge clk);
        end
        n_run++;
        if (done_seen) begin
            $display("FAIL kill_start_idle: got non-idle activity, required idle throughout");
            n_fail++;
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   c;
        bit   done_seen;
        sb_q.push_back(model_div(24'h900000, 24'hF00000));
        div_start = 1'b1; a = 24'h900000; b = 24'hF00000;
        done_seen = 0;
        c = 0;
        while (c < LAT + 8 && !done_seen) begin
            @(negedge clk);
            c++;
            if (c == 1) div_start = 1'b0;
            if (c == 5) begin
                sqrt_start = 1'b1; a = 24'hFFFFFF; b = 24'h800000;
            end
            if (c == 6) sqrt_start = 1'b0;
            if (done_o) done_seen = 1;
        end
        e = sb_q.pop_front();
        n_run++;
        if (!done_seen || c != LAT || result_o !== e.res || sticky_o !== e.st) begin
            $display("FAIL ignore_start: got lat=%0d res=%h st=%b, required lat=%0d res=%h st=%b",
                     c, result_o, sticky_o, LAT, e.res, e.st);
            n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] ra;
        logic [MW-1:0] rb;
        run_op(1'b1, 1'b0, 24'hC00000, 24'h800000, 1'b0, "b2b_div");
        run_op(1'b0, 1'b1, 24'h800000, 24'h000000, 1'b1, "b2b_sqrt");
        run_op(1'b1, 1'b1, 24'h800000, 24'hC00000, 1'b0, "b2b_both");
        for (int i = 0; i < 6; i++) begin
            ra = MW'($urandom); ra[MW-1] = 1'b1;
            rb = MW'($urandom); rb[MW-1] = 1'b1;
            if (i[0]) run_op(1'b0, 1'b1, ra, rb, rb[0], "b2b_rand_sqrt");
            else run_op(1'b1, 1'b0, ra, rb, 1'b0, "b2b_rand_div");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        bit done_seen;
        div_start = 1'b1; a = 24'hC00000; b = 24'h800000;
        for (c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) div_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++;
        if ({ready_o, done_o, busy_o, result_o, sticky_o} !== {3'b100, {RW{1'b0}}, 1'b0}) begin
            $display("FAIL reset_mid: got rdy=%b done=%b busy=%b res=%h st=%b, required 1 0 0 0 0",
                     ready_o, done_o, busy_o, result_o, sticky_o);
            n_fail++;
        end
        done_seen = 0;
        for (c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            if (done_o || busy_o) done_seen = 1;
        end
        n_run++;
        if (done_seen) begin
            $display("FAIL reset_mid_done: got done/busy after reset, required none");
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_sqrt();
        test_kill();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
